// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset/clock-enable sequencer.
//   seq_state_t     - sequencer FSM states
//   DEF_*           - default parameter values for rst_seq_ctrl
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the synchronized reset release
    ST_HOLD = 2'd1,  // all domains held in reset, counting down
    ST_STEP = 2'd2,  // releasing domains one at a time
    ST_DONE = 2'd3   // every domain released
  } seq_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RST_CYCLES  = 10;
  localparam int DEF_STEP_CYCLES = 4;

endpackage

// File: rtl/rst_seq_ctrl_rst_sync.sv
// rst_sync: asynchronous-assert, synchronous-deassert reset synchronizer.
//   clk        - destination clock
//   rst_async  - raw active-low reset
//   rst_synced - active-low reset, drops immediately, rises STAGES edges
//                after rst_async rises
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_async,
  output logic rst_synced
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign rst_synced = chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered multi-domain reset / clock-enable sequencer.
//   clk_fr        - free-running clock
//   rst           - asynchronous active-low reset
//   soft_rst_req  - level request forcing all domains back into reset
//   rst_n_out     - per-domain active-low resets
//   clk_en        - per-domain clock enables (gated clock = clk_fr & clk_en[i])
//   seq_done      - all domains released
//   busy          - sequencer in HOLD or STEP
//   cur_ch        - channel being released (0 outside STEP)
//   dbg_state     - current FSM state, for observation only
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int CNT_W = $clog2(((RST_CYCLES > STEP_CYCLES) ? RST_CYCLES : STEP_CYCLES) + 1),
  parameter int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_fr,
  input  logic              rst,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic              seq_done,
  output logic              busy,
  output logic [CH_W-1:0]   cur_ch,
  output seq_state_t        dbg_state
);

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] FIRST_EN  = NUM_CH'(1);

  logic             rst_synced;
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  ch;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk       (clk_fr),
    .rst_async (rst),
    .rst_synced(rst_synced)
  );

  // The counter sits at HOLD_LOAD while idle, so the edge that sees
  // rst_synced high already counts as the first hold cycle. This lines the
  // power-on and soft-reset paths up on the same release timing.
  always_ff @(posedge clk_fr or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= HOLD_LOAD;
      ch        <= '0;
      clk_en    <= '0;
      rst_n_out <= '0;
    end else begin
      // Each reset follows its clock enable one edge later.
      rst_n_out <= clk_en;
      case (state)
        ST_IDLE: begin
          if (rst_synced) begin
            if (cnt == '0) begin
              state  <= ST_STEP;
              cnt    <= STEP_LOAD;
              ch     <= '0;
              clk_en <= FIRST_EN;
            end else begin
              state <= ST_HOLD;
              cnt   <= cnt - 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (soft_rst_req) begin
            cnt <= HOLD_LOAD;
          end else if (cnt == '0) begin
            state  <= ST_STEP;
            cnt    <= STEP_LOAD;
            ch     <= '0;
            clk_en <= FIRST_EN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STEP: begin
          if (soft_rst_req) begin
            state     <= ST_HOLD;
            cnt       <= HOLD_LOAD;
            ch        <= '0;
            clk_en    <= '0;
            rst_n_out <= '0;
          end else if (ch == LAST_CH) begin
            // Finish once the last domain's reset has actually risen.
            if (rst_n_out[NUM_CH-1]) begin
              state <= ST_DONE;
              ch    <= '0;
            end
          end else if (cnt == '0) begin
            ch     <= ch + 1'b1;
            cnt    <= STEP_LOAD;
            clk_en <= (clk_en << 1) | FIRST_EN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (soft_rst_req) begin
            state     <= ST_HOLD;
            cnt       <= HOLD_LOAD;
            ch        <= '0;
            clk_en    <= '0;
            rst_n_out <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= HOLD_LOAD;
        end
      endcase
    end
  end

  // Pure decodes of registered state; no input reaches an output directly.
  assign seq_done  = (state == ST_DONE);
  assign busy      = (state == ST_HOLD) || (state == ST_STEP);
  assign cur_ch    = ch;
  assign dbg_state = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: bench for rst_seq_ctrl with a timing-formula reference
// model, directed scenarios, randomized soft-reset / rst-glitch stimulus and
// a corner-configuration instance.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int R  = 10;
  localparam int S  = 4;

  // ---------------- clock / reset ----------------
  logic clk_fr = 1'b0;
  always #5 clk_fr = ~clk_fr;

  logic rst, soft_rst_req;
  logic rst2, soft2;

  logic [N-1:0] rst_n_out, clk_en;
  logic         seq_done, busy;
  logic [1:0]   cur_ch;
  seq_state_t   dbg_state;

  logic [0:0]   rst_n_out2, clk_en2, cur_ch2;
  logic         seq_done2, busy2;
  seq_state_t   dbg_state2;

  rst_seq_ctrl #(
    .NUM_CH(N), .SYNC_STAGES(SS), .RST_CYCLES(R), .STEP_CYCLES(S)
  ) dut (
    .clk_fr(clk_fr), .rst(rst), .soft_rst_req(soft_rst_req),
    .rst_n_out(rst_n_out), .clk_en(clk_en), .seq_done(seq_done),
    .busy(busy), .cur_ch(cur_ch), .dbg_state(dbg_state)
  );

  rst_seq_ctrl #(
    .NUM_CH(1), .SYNC_STAGES(2), .RST_CYCLES(1), .STEP_CYCLES(2)
  ) dut2 (
    .clk_fr(clk_fr), .rst(rst2), .soft_rst_req(soft2),
    .rst_n_out(rst_n_out2), .clk_en(clk_en2), .seq_done(seq_done2),
    .busy(busy2), .cur_ch(cur_ch2), .dbg_state(dbg_state2)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // ---------------- reference model ----------------
  // d counts edges since the reference point: the edge rst_sync rises, or the
  // last edge a soft request was honoured. Outputs follow from d by formula.
  bit m_started, m_from_soft;
  int m_k, m_d;

  always @(posedge clk_fr or negedge rst) begin
    if (!rst) begin
      m_started = 1'b0; m_from_soft = 1'b0; m_k = 0; m_d = 0;
    end else if (!m_started) begin
      m_k++;
      if (m_k == SS) begin
        m_started = 1'b1; m_d = 0; m_from_soft = 1'b0;
      end
    end else if (soft_rst_req && (m_d >= 1 || m_from_soft)) begin
      m_d = 0; m_from_soft = 1'b1;
    end else if (m_d < 1000) begin
      m_d++;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_fr);
    #2;
  endtask

  always @(posedge clk_fr) begin
    #2;
    if (cmp_en) begin
      logic [N-1:0] e_en, e_rn;
      logic e_done, e_busy;
      logic [1:0] e_cur;
      int c;
      for (int i = 0; i < N; i++) begin
        e_en[i] = m_started && (m_d >= R + i * S);
        e_rn[i] = m_started && (m_d >= R + i * S + 1);
      end
      e_done = m_started && (m_d >= R + (N - 1) * S + 2);
      e_busy = m_started && !e_done && (m_d >= 1 || m_from_soft);
      e_cur  = 2'd0;
      if (m_started && m_d >= R && !e_done) begin
        c = (m_d - R) / S;
        if (c > N - 1) c = N - 1;
        e_cur = 2'(c);
      end
      checks++;
      if ({rst_n_out, clk_en, seq_done, busy, cur_ch} !== {e_rn, e_en, e_done, e_busy, e_cur}) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t rst_n_out=%b/%b clk_en=%b/%b done=%b/%b busy=%b/%b cur_ch=%0d/%0d (actual/required)",
                 $time, rst_n_out, e_rn, clk_en, e_en, seq_done, e_done, busy, e_busy, cur_ch, e_cur);
      end
      checks++;
      if (((rst_n_out & ~clk_en) != '0) || ((rst_n_out & (rst_n_out + 1'b1)) != '0)) begin
        failures++;
        $display("FAIL order_inv t=%0t rst_n_out=%b clk_en=%b", $time, rst_n_out, clk_en);
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_rst_n"}, 32'(rst_n_out), 32'h0);
    chk({name, "_clk_en"}, 32'(clk_en), 32'h0);
    chk({name, "_done"}, 32'(seq_done), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_cur"}, 32'(cur_ch), 32'h0);
  endtask

  // Wait for a condition on rst_n_out with a cycle budget; returns edges used.
  task automatic wait_rn(input logic [N-1:0] pat, input int budget, output int used);
    used = -1;
    for (int i = 1; i <= budget; i++) begin
      wait_edges(1);
      if (rst_n_out == pat) begin
        used = i;
        break;
      end
    end
    if (used < 0) begin
      checks++; failures++;
      $display("FAIL wait_rn timeout pattern=%b actual=%b", pat, rst_n_out);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int used;
    rst = 1'b0; soft_rst_req = 1'b0; rst2 = 1'b0; soft2 = 1'b0;
    cmp_en = 1'b1;

    // Power-on
    repeat (5) @(posedge clk_fr);
    #2;
    chk_all_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk_fr); rst = 1'b1;
    wait_edges(2);  chk("po_t0_busy", 32'(busy), 32'h0);
    wait_edges(1);  chk("po_t1_busy", 32'(busy), 32'h1);
    wait_edges(8);  chk("po_e11_en", 32'(clk_en), 32'h0);
    wait_edges(1);  chk("po_e12_en", 32'(clk_en), 32'h1);
                    chk("po_e12_rn", 32'(rst_n_out), 32'h0);
    wait_edges(1);  chk("po_e13_rn", 32'(rst_n_out), 32'h1);
    wait_edges(3);  chk("po_e16_en", 32'(clk_en), 32'h3);
    wait_edges(4);  chk("po_e20_en", 32'(clk_en), 32'h7);
    wait_edges(4);  chk("po_e24_en", 32'(clk_en), 32'hf);
                    chk("po_e24_cur", 32'(cur_ch), 32'h3);
    wait_edges(1);  chk("po_e25_rn", 32'(rst_n_out), 32'hf);
                    chk("po_e25_done", 32'(seq_done), 32'h0);
    wait_edges(1);  chk("po_e26_done", 32'(seq_done), 32'h1);
                    chk("po_e26_busy", 32'(busy), 32'h0);

    // Soft reset in DONE, 3 cycles
    @(negedge clk_fr); soft_rst_req = 1'b1;
    wait_edges(1);
    chk("sd_rn", 32'(rst_n_out), 32'h0);
    chk("sd_en", 32'(clk_en), 32'h0);
    chk("sd_done", 32'(seq_done), 32'h0);
    chk("sd_busy", 32'(busy), 32'h1);
    wait_edges(2);
    @(negedge clk_fr); soft_rst_req = 1'b0;
    wait_edges(9);  chk("sd_e9_en", 32'(clk_en), 32'h0);
    wait_edges(1);  chk("sd_e10_en", 32'(clk_en), 32'h1);
    wait_edges(13); chk("sd_e23_done", 32'(seq_done), 32'h0);
    wait_edges(1);  chk("sd_e24_done", 32'(seq_done), 32'h1);

    // Soft reset during STEP at the rst_n_out[1] rise edge
    @(negedge clk_fr); soft_rst_req = 1'b1;
    wait_edges(1);
    @(negedge clk_fr); soft_rst_req = 1'b0;
    wait_rn(4'b0011, 60, used);
    chk("ss_rn1_edge", 32'(used), 32'd15);
    soft_rst_req = 1'b1;
    wait_edges(1);
    chk("ss_rn", 32'(rst_n_out), 32'h0);
    chk("ss_cur", 32'(cur_ch), 32'h0);
    chk("ss_busy", 32'(busy), 32'h1);
    wait_edges(1);
    @(negedge clk_fr); soft_rst_req = 1'b0;
    wait_edges(23); chk("ss_e23_done", 32'(seq_done), 32'h0);
    wait_edges(1);  chk("ss_e24_done", 32'(seq_done), 32'h1);

    // Async reset mid-sequence
    @(negedge clk_fr); soft_rst_req = 1'b1;
    wait_edges(1);
    @(negedge clk_fr); soft_rst_req = 1'b0;
    wait_rn(4'b0011, 60, used);
    #1; rst = 1'b0; #1;
    chk_all_zero("async");
    wait_edges(2);
    @(negedge clk_fr); rst = 1'b1;
    wait_edges(2);  chk("ar_t0_en", 32'(clk_en), 32'h0);
                    chk("ar_t0_busy", 32'(busy), 32'h0);
    wait_edges(10); chk("ar_e12_en", 32'(clk_en), 32'h1);
    wait_edges(14); chk("ar_e26_done", 32'(seq_done), 32'h1);

    // Sub-cycle rst glitch while in DONE
    #1; rst = 1'b0; #1;
    chk_all_zero("glitch");
    #1; rst = 1'b1;
    wait_edges(2);  chk("gl_t0_busy", 32'(busy), 32'h0);
    wait_edges(23); chk("gl_e25_done", 32'(seq_done), 32'h0);
    wait_edges(1);  chk("gl_e26_done", 32'(seq_done), 32'h1);

    // Randomized soft requests and short rst glitches
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_fr);
      if (soft_rst_req) soft_rst_req = ($urandom_range(0, 2) != 0);
      else              soft_rst_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1; rst = 1'b0;
        #($urandom_range(1, 3));
        rst = 1'b1;
      end
    end
    @(negedge clk_fr); soft_rst_req = 1'b0;
    wait_edges(40);
    chk("rand_end_done", 32'(seq_done), 32'h1);

    // Corner configuration: NUM_CH=1, RST_CYCLES=1, STEP_CYCLES=2
    chk("cn_reset_en", 32'(clk_en2), 32'h0);
    @(negedge clk_fr); rst2 = 1'b1;
    wait_edges(2);  chk("cn_t0_en", 32'(clk_en2), 32'h0);
                    chk("cn_t0_busy", 32'(busy2), 32'h0);
    wait_edges(1);  chk("cn_t1_en", 32'(clk_en2), 32'h1);
                    chk("cn_t1_rn", 32'(rst_n_out2), 32'h0);
                    chk("cn_t1_busy", 32'(busy2), 32'h1);
    wait_edges(1);  chk("cn_t2_rn", 32'(rst_n_out2), 32'h1);
                    chk("cn_t2_done", 32'(seq_done2), 32'h0);
                    chk("cn_t2_cur", 32'(cur_ch2), 32'h0);
    wait_edges(1);  chk("cn_t3_done", 32'(seq_done2), 32'h1);
                    chk("cn_t3_busy", 32'(busy2), 32'h0);
    @(negedge clk_fr); soft2 = 1'b1;
    wait_edges(1);  chk("cn_soft_rn", 32'(rst_n_out2), 32'h0);
                    chk("cn_soft_en", 32'(clk_en2), 32'h0);
    @(negedge clk_fr); soft2 = 1'b0;
    wait_edges(1);  chk("cn_s1_en", 32'(clk_en2), 32'h1);
    wait_edges(1);  chk("cn_s2_rn", 32'(rst_n_out2), 32'h1);
    wait_edges(1);  chk("cn_s3_done", 32'(seq_done2), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
